// File: rtl/rx_ctrl_pkg.sv
// Shared types and helpers for the receiver phase-acquisition controller.
// Holds the FSM state encoding, default geometry and the saturating magnitude.
package rx_ctrl_pkg;

    localparam int OS_DEF       = 4;
    localparam int LOG2_WIN_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        DECIDE,
        LOCKED
    } state_t;

    // |x| for an nb-bit two's complement value; the most negative code maps
    // to the most positive one so the result always fits in nb bits.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int nb);
        logic signed [31:0] min_v;
        min_v = -(32'sd1 <<< (nb - 1));
        if (x == min_v) begin
            return (32'd1 << (nb - 1)) - 32'd1;
        end
        return (x < 0) ? 32'(-x) : 32'(x);
    endfunction

endpackage

// File: rtl/phase_energy_acc.sv
// Bank of OS saturating energy accumulators, one per oversampling phase.
// The accumulator addressed by i_phase absorbs i_sum whenever i_en is high.
module phase_energy_acc #(
    parameter int OS     = 4,
    parameter int NB_PH  = 2,
    parameter int NB_IN  = 8,
    parameter int NB_ACC = 16
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_clear,
    input  logic                         i_en,
    input  logic [NB_PH-1:0]             i_phase,
    input  logic [NB_IN-1:0]             i_sum,
    output logic [OS-1:0][NB_ACC-1:0]    o_acc
);

    logic [NB_ACC:0] sum_ext;

    assign sum_ext = {1'b0, o_acc[i_phase]} + (NB_ACC + 1)'(i_sum);

    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            o_acc <= '0;
        end else if (i_en) begin
            o_acc[i_phase] <= sum_ext[NB_ACC] ? '1 : sum_ext[NB_ACC-1:0];
        end
    end

endmodule

// File: rtl/rx_phase_sel_ctrl.sv
// Timing-acquisition controller: measures |I|+|Q| energy per oversampling phase
// over a window, locks on the strongest phase and emits the downsampler strobe.
//   state   | meaning
//   IDLE    | no selection held, waiting for i_start
//   ARM     | accumulators cleared, waiting for the symbol boundary
//   MEASURE | accumulating energy per phase over the window
//   DECIDE  | sequential arg-max over the OS accumulators
//   LOCKED  | selection held, strobe active
module rx_phase_sel_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int NBT_IN   = 8,
    parameter int NBF_IN   = 7,
    parameter int OS       = OS_DEF,
    parameter int LOG2_WIN = LOG2_WIN_DEF,
    parameter int NB_PH    = $clog2(OS),
    parameter int NB_ACC   = NBT_IN + LOG2_WIN
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic [NB_PH-1:0]         i_phase,
    input  logic signed [NBT_IN-1:0] i_sym_I,
    input  logic signed [NBT_IN-1:0] i_sym_Q,
    input  logic                     i_start,
    output logic [NB_PH-1:0]         o_phase_sel,
    output logic                     o_locked,
    output logic                     o_busy,
    output logic                     o_sample_en
);

    localparam logic [NB_PH-1:0]    PH_LAST  = NB_PH'(OS - 1);
    localparam logic [LOG2_WIN-1:0] SYM_LAST = '1;

    if (NBF_IN >= NBT_IN) begin : g_fmt_check
        $error("NBF_IN must be smaller than NBT_IN");
    end

    state_t                    state, state_next;
    logic [LOG2_WIN-1:0]       sym_cnt;
    logic [NB_PH-1:0]          dec_idx, best_idx;
    logic [NB_ACC-1:0]         best_val;
    logic [OS-1:0][NB_ACC-1:0] acc;
    logic                      acc_clear, acc_en, cand_better, last_sym;
    logic [NBT_IN-1:0]         abs_i, abs_q, sample_sum;

    // Both magnitudes are at most 2^(NBT_IN-1)-1, so their sum fits in NBT_IN bits.
    assign abs_i      = NBT_IN'(sat_abs(32'(i_sym_I), NBT_IN));
    assign abs_q      = NBT_IN'(sat_abs(32'(i_sym_Q), NBT_IN));
    assign sample_sum = abs_i + abs_q;

    assign cand_better = acc[dec_idx] > best_val;
    assign last_sym    = (i_phase == PH_LAST) && (sym_cnt == SYM_LAST);

    phase_energy_acc #(
        .OS     (OS),
        .NB_PH  (NB_PH),
        .NB_IN  (NBT_IN),
        .NB_ACC (NB_ACC)
    ) u_acc (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clear (acc_clear),
        .i_en    (acc_en),
        .i_phase (i_phase),
        .i_sum   (sample_sum),
        .o_acc   (acc)
    );

    always_comb begin
        state_next = state;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        unique case (state)
            IDLE, LOCKED: begin
                if (i_start) begin
                    state_next = ARM;
                    acc_clear  = 1'b1;
                end
            end
            ARM: begin
                if (i_phase == PH_LAST) state_next = MEASURE;
            end
            MEASURE: begin
                acc_en = 1'b1;
                if (last_sym) state_next = DECIDE;
            end
            DECIDE: begin
                if (dec_idx == PH_LAST) state_next = LOCKED;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state       <= IDLE;
            sym_cnt     <= '0;
            dec_idx     <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            o_phase_sel <= '0;
            o_locked    <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state  <= state_next;
            o_busy <= (state_next == ARM) || (state_next == MEASURE) || (state_next == DECIDE);
            if (acc_clear) begin
                sym_cnt  <= '0;
                o_locked <= 1'b0;
            end
            if (acc_en && (i_phase == PH_LAST)) sym_cnt <= sym_cnt + 1'b1;
            if (state == MEASURE) begin
                dec_idx  <= '0;
                best_idx <= '0;
                best_val <= '0;
            end
            // Strictly-greater update keeps the lowest index on ties.
            if (state == DECIDE) begin
                dec_idx <= dec_idx + 1'b1;
                if (cand_better) begin
                    best_val <= acc[dec_idx];
                    best_idx <= dec_idx;
                end
                if (dec_idx == PH_LAST) begin
                    o_phase_sel <= cand_better ? dec_idx : best_idx;
                    o_locked    <= 1'b1;
                end
            end
        end
    end

    assign o_sample_en = o_locked & (i_phase == o_phase_sel);

endmodule

// File: tb/tb_rx_phase_sel_ctrl.sv
// Self-checking bench for rx_phase_sel_ctrl with OS=4 and a 16-symbol window.
// Per-phase sample patterns drive acquisitions; lock time and phase are scoreboarded.
module tb_rx_phase_sel_ctrl;

    localparam int OS  = 4;
    localparam int LW  = 4;
    localparam int WIN = 16;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [1:0]        i_phase;
    logic signed [7:0] i_sym_I, i_sym_Q;
    logic              i_start;
    logic [1:0]        o_phase_sel;
    logic              o_locked, o_busy, o_sample_en;

    always #5 clk = ~clk;

    rx_phase_sel_ctrl #(
        .NBT_IN   (8),
        .NBF_IN   (7),
        .OS       (OS),
        .LOG2_WIN (LW)
    ) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_phase     (i_phase),
        .i_sym_I     (i_sym_I),
        .i_sym_Q     (i_sym_Q),
        .i_start     (i_start),
        .o_phase_sel (o_phase_sel),
        .o_locked    (o_locked),
        .o_busy      (o_busy),
        .o_sample_en (o_sample_en)
    );

    typedef struct {
        string           name;
        logic [0:3][7:0] vi;
        logic [0:3][7:0] vq;
        logic [1:0]      exp_ph;
    } vec_t;

    typedef struct {
        int         exp_cycle;
        logic [1:0] exp_phase;
    } exp_t;

    vec_t              vecs[6];
    exp_t              sb[$];
    logic signed [7:0] pat_i[4];
    logic signed [7:0] pat_q[4];
    int                cyc;
    int                total;
    int                bad;

    task automatic check(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Advance one cycle: new phase/data just after the edge, return at negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        i_phase = i_phase + 2'd1;
        i_sym_I = pat_i[i_phase];
        i_sym_Q = pat_q[i_phase];
        @(negedge clk);
    endtask

    task automatic set_pattern(input logic [0:3][7:0] vi, input logic [0:3][7:0] vq);
        for (int p = 0; p < 4; p++) begin
            pat_i[p] = $signed(vi[p]);
            pat_q[p] = $signed(vq[p]);
        end
    endtask

    task automatic acquire(input string nm, input logic [1:0] exp_ph, input bit extra_starts);
        exp_t e;
        int   t;
        int   w;
        int   waited;
        bit   en_bad;
        t = cyc;
        w = OS - ((int'(i_phase) + 1) % OS);
        e.exp_cycle = t + w + OS * WIN + OS + 1;
        e.exp_phase = exp_ph;
        sb.push_back(e);
        i_start = 1'b1;
        next_cycle();
        i_start = 1'b0;
        check({nm, "_busy_rise"}, int'(o_busy), 1);
        check({nm, "_lock_drop"}, int'(o_locked), 0);
        en_bad = 1'b0;
        waited = 0;
        while (!o_locked && waited < 200) begin
            if (o_sample_en) en_bad = 1'b1;
            if (extra_starts && (cyc == t + 30 || cyc == sb[0].exp_cycle - 2)) i_start = 1'b1;
            else i_start = 1'b0;
            next_cycle();
            waited++;
        end
        i_start = 1'b0;
        check({nm, "_strobe_quiet"}, int'(en_bad), 0);
        if (!o_locked) begin
            check({nm, "_lock_timeout"}, int'(o_locked), 1);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check({nm, "_lock_cycle"}, cyc, e.exp_cycle);
            check({nm, "_phase"}, int'(o_phase_sel), int'(e.exp_phase));
            check({nm, "_busy_fall"}, int'(o_busy), 0);
            en_bad = 1'b0;
            repeat (8) begin
                if (o_sample_en != (i_phase == e.exp_phase)) en_bad = 1'b1;
                next_cycle();
            end
            check({nm, "_strobe"}, int'(en_bad), 0);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        i_phase = 2'd0;
        i_sym_I = '0;
        i_sym_Q = '0;
        for (int p = 0; p < 4; p++) begin
            pat_i[p] = '0;
            pat_q[p] = '0;
        end

        vecs[0] = '{"clean",   {8'sd10, -8'sd10, 8'sd100, 8'sd10},   {-8'sd10, -8'sd10, 8'sd100, 8'sd10}, 2'd2};
        vecs[1] = '{"peak0",   {8'sd100, 8'sd10, -8'sd10, 8'sd10},   {8'sd100, -8'sd10, 8'sd10, -8'sd10}, 2'd0};
        vecs[2] = '{"tie_sat", {8'h00, 8'h80, 8'h00, 8'h80},         {8'h00, 8'h80, 8'h00, 8'h80},        2'd1};
        vecs[3] = '{"mixed",   {8'sd127, -8'sd127, 8'sd0, -8'sd100}, {8'sd0, -8'sd20, 8'sd0, 8'sd50},     2'd3};
        vecs[4] = '{"abs_min", {8'h80, 8'h00, 8'sd127, 8'h00},       {8'h00, 8'h00, 8'sd1, 8'h00},        2'd2};
        vecs[5] = '{"zeros",   {8'h00, 8'h00, 8'h00, 8'h00},         {8'h00, 8'h00, 8'h00, 8'h00},        2'd0};

        // Reset held with a pending start: everything stays cleared.
        i_reset = 1'b1;
        i_start = 1'b1;
        repeat (3) begin
            next_cycle();
            check("rst_locked", int'(o_locked), 0);
            check("rst_busy", int'(o_busy), 0);
            check("rst_phase_sel", int'(o_phase_sel), 0);
            check("rst_sample_en", int'(o_sample_en), 0);
        end
        i_reset = 1'b0;
        i_start = 1'b0;
        repeat (6) begin
            next_cycle();
            check("idle_busy", int'(o_busy), 0);
            check("idle_locked", int'(o_locked), 0);
        end

        for (int k = 0; k < 6; k++) begin
            set_pattern(vecs[k].vi, vecs[k].vq);
            acquire(vecs[k].name, vecs[k].exp_ph, 1'b0);
        end

        // Abort mid-measurement, then a fresh acquisition on a different peak.
        set_pattern({8'sd10, 8'sd120, 8'sd10, 8'sd10}, {8'sd10, 8'sd120, 8'sd10, 8'sd10});
        i_start = 1'b1;
        next_cycle();
        i_start = 1'b0;
        repeat (20) next_cycle();
        check("abort_pre_busy", int'(o_busy), 1);
        i_reset = 1'b1;
        next_cycle();
        i_reset = 1'b0;
        check("abort_busy", int'(o_busy), 0);
        check("abort_locked", int'(o_locked), 0);
        check("abort_phase_sel", int'(o_phase_sel), 0);
        check("abort_sample_en", int'(o_sample_en), 0);
        repeat (3) next_cycle();
        check("abort_stays_idle", int'(o_busy), 0);
        set_pattern({8'sd10, 8'sd10, 8'sd10, 8'sd30}, {8'sd10, 8'sd10, 8'sd10, 8'sd30});
        acquire("post_abort", 2'd3, 1'b0);

        // Starts during MEASURE and DECIDE must not disturb the clean lock.
        set_pattern(vecs[0].vi, vecs[0].vq);
        acquire("ign_start", 2'd2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_phase_sel_ctrl.md
# rx_phase_sel_ctrl

Receiver timing-acquisition controller placed after the anti-alias filters, between the symbol-rate control counter and the downsamplers / FSE. Over a programmable window it measures the mean |I|+|Q| amplitude at each of the OS oversampling phases and picks the phase with the largest energy. It then locks and emits the sample-enable strobe that replaces the fixed rate enable on the downsampler. Re-acquisition is requested by a start pulse.

## Interface
- NBT_IN, 8: total bits of the signed I/Q input samples.
- NBF_IN, 7: fractional bits of the input. Carried for documentation only; the arithmetic is integer.
- OS, 4: oversampling factor, a power of 2. This is the number of candidate phases.
- LOG2_WIN, 8: the measurement window is 2^LOG2_WIN symbols.
- NB_PH, $clog2(OS): phase index width.
- NB_ACC, NBT_IN+LOG2_WIN: accumulator width.

Ports:
- clk, input, 1: system clock. One oversampled sample per cycle.
- i_reset, input, 1: synchronous, active-high reset.
- i_phase, input, NB_PH: current oversampling phase from the control counter. Increments modulo OS every cycle.
- i_sym_I, input, NBT_IN: signed in-phase sample (AA filter output).
- i_sym_Q, input, NBT_IN: signed quadrature sample.
- i_start, input, 1: single-cycle acquisition request.
- o_phase_sel, output, NB_PH: selected phase.
- o_locked, output, 1: a valid phase selection is held.
- o_busy, output, 1: acquisition in progress.
- o_sample_en, output, 1: downsampler enable, asserted once per symbol at the selected phase.

## Operation
- FSM states:
  - IDLE, reset state.
  - ARM: wait for symbol boundary.
  - MEASURE.
  - DECIDE.
  - LOCKED.
- IDLE/LOCKED → ARM on i_start. On entering ARM:
  - clear all OS accumulators and the symbol counter;
  - deassert o_locked;
  - keep o_phase_sel at its previous value.
- ARM → MEASURE in the cycle where i_phase == OS-1. Measurement therefore starts at phase 0.
- MEASURE, every cycle:
  - acc[i_phase] += |I| + |Q|.
  - |x| saturates: |−2^(NBT_IN−1)| = 2^(NBT_IN−1)−1.
  - The sum width is NBT_IN bits (unsigned), so no overflow is possible in NB_ACC.
  - The symbol counter increments on each i_phase == OS-1 sample.
  - After the OS-1 sample of symbol 2^LOG2_WIN−1 is accumulated, go to DECIDE.
- DECIDE: sequential compare over OS cycles, indices 0..OS-1.
  - Update the best candidate only on strictly greater, so ties resolve to the lowest index.
  - On the last index, load o_phase_sel and go to LOCKED.
- LOCKED: hold o_phase_sel with o_locked = 1.
- i_start while in ARM, MEASURE or DECIDE: ignored.
- o_busy = 1 in ARM, MEASURE and DECIDE.
- o_sample_en = o_locked & (i_phase == o_phase_sel).
  - Combinational, zero latency, aligned with the i_sym_* sample on the same cycle.
  - 0 when unlocked; downstream holds its last sample.
- Reset, including mid-operation: go to IDLE; clear accumulators, counters, o_phase_sel = 0, o_locked = 0, o_busy = 0, o_sample_en = 0.

## Timing
- i_start in cycle t → o_busy = 1 at t+1.
- MEASURE lasts exactly OS·2^LOG2_WIN cycles.
- DECIDE lasts OS cycles. o_locked rises on the cycle after the last compare, together with the new o_phase_sel.
- Total cycles from i_start to o_locked = ARM wait (1..OS) + OS·2^LOG2_WIN + OS + 1.
  - With defaults: between 1030 and 1033 cycles.
- All outputs are registered except o_sample_en.
- Accumulators saturate at the all-ones value, as a safeguard if LOG2_WIN is overridden against NB_ACC.

## Structure
- Shared package rx_ctrl_pkg holds:
  - the FSM state typedef (IDLE, ARM, MEASURE, DECIDE, LOCKED);
  - the saturating abs function;
  - default constants for OS and LOG2_WIN, shared with the control module.
- One sub-module, phase_energy_acc: holds the OS saturating accumulators indexed by i_phase, with clear and enable inputs.
- The FSM, the compare logic and the strobe decode stay in the top.

## Test plan
- Reset: hold i_reset for 3 cycles with i_start = 1 → all outputs 0. After release, stays IDLE until a fresh i_start.
- Clean lock: I = Q = +100 at phase 2 and ±10 elsewhere, LOG2_WIN = 4, OS = 4.
  - o_locked rises exactly 4·16 + 4 + 1 + ARM-wait cycles after i_start.
  - o_phase_sel = 2.
  - o_sample_en pulses only when i_phase = 2.
- Tie and saturation: I = −128, Q = −128 at phases 1 and 3, zero elsewhere.
  - Each sample contributes 254.
  - o_phase_sel = 1 (lowest index wins the tie).
- Re-acquire: after locking on phase 2, move the peak to phase 0 and pulse i_start.
  - o_locked drops the next cycle and o_sample_en stays 0 during acquisition.
  - o_phase_sel = 0 after the new lock.
- Abort: assert i_reset mid-MEASURE → next cycle is IDLE with o_busy = 0. A fresh i_start then yields a correct lock with no residual accumulator content.
- Ignored start: pulse i_start during MEASURE and again during DECIDE → lock timing and result are identical to the clean-lock case.
